// File: rtl/bus_mem_slave.sv
// Main-memory slave on the shared system bus: base/window address decode,
// programmable wait states, single-cycle ready strobe and tri-stated read data.
module bus_mem_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      BUS_addr,
  inout  wire logic [31:0] BUS_data,
  input  logic             BUS_req,
  input  logic             BUS_RW,
  output logic             BUS_ready,
  output logic             busy
);

  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [29:0] BASE_WORD = ADDR_BASE[31:2];
  localparam logic [3:0]  WAIT_LD   = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_DONE
  } state_t;

  state_t                  state, state_n;
  logic [3:0]              cnt_q, cnt_n;
  logic [ADDR_WIDTH-1:0]   idx_q, dec_idx, rd_idx;
  logic                    rw_q;
  logic [31:0]             wdata_q, rdata_q;
  logic [29:0]             offset;
  logic                    hit, accept;
  logic                    unused_byte_lane;
  logic [31:0]             mem [DEPTH];

  assign unused_byte_lane = ^BUS_addr[1:0];

  // Unsigned offset from the base: addresses below the base wrap to huge values and miss.
  assign offset  = BUS_addr[31:2] - BASE_WORD;
  assign hit     = (offset >> ADDR_WIDTH) == '0;
  assign dec_idx = offset[ADDR_WIDTH-1:0];
  assign accept  = (state == ST_IDLE) && BUS_req && hit;
  assign rd_idx  = (state == ST_IDLE) ? dec_idx : idx_q;

  always_comb begin
    state_n = state;
    cnt_n   = cnt_q;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          cnt_n   = WAIT_LD;
          state_n = (WAIT_LD == '0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!BUS_req) begin
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_n = ST_RESP;
        end
      end
      ST_RESP: state_n = ST_DONE;
      ST_DONE: if (!BUS_req) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      cnt_q <= cnt_n;
      if (accept) begin
        idx_q   <= dec_idx;
        rw_q    <= BUS_RW;
        wdata_q <= BUS_data;
      end
      // Read data is captured on entry to RESP, including the zero-wait path out of IDLE.
      if (state_n == ST_RESP) rdata_q <= mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_RESP && rw_q) mem[idx_q] <= wdata_q;
  end

  assign BUS_ready = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);
  assign BUS_data  = (state == ST_RESP && !rw_q) ? rdata_q : 'z;

endmodule

// File: tb/tb_bus_mem_slave.sv
// Directed bench for bus_mem_slave: three instances cover WAIT_STATES=2, WAIT_STATES=0
// and a non-zero base with a 16-word window.
module tb_bus_mem_slave;

  logic        clk = 1'b0;
  logic        clr;
  logic [2:0]  req, rw, mdrv;
  logic [31:0] addr  [3];
  logic [31:0] mdata [3];
  wire  [31:0] bus0, bus1, bus2;
  logic        rdy0, rdy1, rdy2, bsy0, bsy1, bsy2;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign bus0 = mdrv[0] ? mdata[0] : 'z;
  assign bus1 = mdrv[1] ? mdata[1] : 'z;
  assign bus2 = mdrv[2] ? mdata[2] : 'z;

  bus_mem_slave #(.ADDR_BASE(32'h0000_0000), .ADDR_WIDTH(10), .WAIT_STATES(2)) u_w2 (
    .clk(clk), .clr(clr), .BUS_addr(addr[0]), .BUS_data(bus0), .BUS_req(req[0]),
    .BUS_RW(rw[0]), .BUS_ready(rdy0), .busy(bsy0));

  bus_mem_slave #(.ADDR_BASE(32'h0000_0000), .ADDR_WIDTH(10), .WAIT_STATES(0)) u_w0 (
    .clk(clk), .clr(clr), .BUS_addr(addr[1]), .BUS_data(bus1), .BUS_req(req[1]),
    .BUS_RW(rw[1]), .BUS_ready(rdy1), .busy(bsy1));

  bus_mem_slave #(.ADDR_BASE(32'h0000_1000), .ADDR_WIDTH(4), .WAIT_STATES(2)) u_win (
    .clk(clk), .clr(clr), .BUS_addr(addr[2]), .BUS_data(bus2), .BUS_req(req[2]),
    .BUS_RW(rw[2]), .BUS_ready(rdy2), .busy(bsy2));

  typedef struct {
    int unsigned u;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned hold;
    logic        hit;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic logic get_ready(input int unsigned u);
    case (u)
      0:       return rdy0;
      1:       return rdy1;
      default: return rdy2;
    endcase
  endfunction

  function automatic logic get_busy(input int unsigned u);
    case (u)
      0:       return bsy0;
      1:       return bsy1;
      default: return bsy2;
    endcase
  endfunction

  function automatic logic [31:0] get_bus(input int unsigned u);
    case (u)
      0:       return bus0;
      1:       return bus1;
      default: return bus2;
    endcase
  endfunction

  function automatic int unsigned waits_of(input int unsigned u);
    return (u == 1) ? 0 : 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // A released bus reads as z on 4-state simulators and as 0 where tristates resolve 2-state.
  task automatic chk_rel(input string name, input logic [31:0] got);
    checks++;
    if (!(got === 32'bz || got === 32'h0)) begin
      errors++;
      $display("FAIL %s got %h expected released bus", name, got);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int unsigned lat;
    int unsigned pulses;
    logic        busy_seen;
    @(negedge clk);
    addr[v.u]  = v.addr;
    rw[v.u]    = v.rw;
    mdata[v.u] = v.wdata;
    mdrv[v.u]  = v.rw;
    req[v.u]   = 1'b1;
    @(posedge clk); #1;
    chk({tag, " busy_after_accept"}, 32'(get_busy(v.u)), 32'(v.hit));
    busy_seen  = get_busy(v.u);
    addr[v.u]  = v.addr ^ 32'h0000_0010;
    rw[v.u]    = ~v.rw;
    mdata[v.u] = 32'hDEAD_BEEF;
    lat = 0;
    while (!get_ready(v.u) && lat < 12) begin
      @(posedge clk); #1;
      busy_seen = busy_seen | get_busy(v.u);
      lat++;
    end
    if (v.hit) begin
      chk({tag, " latency"}, lat, waits_of(v.u));
      if (!v.rw) chk({tag, " rdata"}, get_bus(v.u), v.rdata);
      @(posedge clk); #1;
      chk({tag, " ready_single"}, 32'(get_ready(v.u)), 32'h0);
      if (!v.rw) chk_rel({tag, " bus_after_resp"}, get_bus(v.u));
      pulses = 1;
      repeat (v.hold) begin
        @(posedge clk); #1;
        if (get_ready(v.u)) pulses++;
      end
      chk({tag, " ready_pulses"}, pulses, 1);
    end else begin
      chk({tag, " miss_no_ready"}, 32'(get_ready(v.u)), 32'h0);
      chk({tag, " miss_never_busy"}, 32'(busy_seen), 32'h0);
      chk_rel({tag, " miss_bus"}, get_bus(v.u));
    end
    @(negedge clk);
    req[v.u]  = 1'b0;
    mdrv[v.u] = 1'b0;
    @(posedge clk); #1;
    chk({tag, " idle_after_release"}, 32'(get_busy(v.u)), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        rv;
    int unsigned rdy_cnt;

    //            u  rw    addr          wdata          hold hit   rdata
    vecs.push_back('{0, 1'b1, 32'h0000_0004, 32'h0ab2_112a, 0,  1'b1, 32'h0});
    vecs.push_back('{0, 1'b0, 32'h0000_0004, 32'h0,         0,  1'b1, 32'h0ab2_112a});
    vecs.push_back('{0, 1'b1, 32'h0000_0008, 32'h1111_2222, 0,  1'b1, 32'h0});
    vecs.push_back('{0, 1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 0,  1'b1, 32'h0});
    vecs.push_back('{0, 1'b0, 32'h0000_0FFC, 32'h0,         0,  1'b1, 32'hCAFE_F00D});
    vecs.push_back('{0, 1'b0, 32'h0000_1000, 32'h0,         0,  1'b0, 32'h0});
    vecs.push_back('{0, 1'b1, 32'h0000_000E, 32'h5A5A_0001, 10, 1'b1, 32'h0});
    vecs.push_back('{0, 1'b0, 32'h0000_000D, 32'h0,         0,  1'b1, 32'h5A5A_0001});
    vecs.push_back('{1, 1'b1, 32'h0000_0010, 32'h1357_9BDF, 0,  1'b1, 32'h0});
    vecs.push_back('{1, 1'b0, 32'h0000_0010, 32'h0,         0,  1'b1, 32'h1357_9BDF});
    vecs.push_back('{2, 1'b0, 32'h0000_0FFC, 32'h0,         0,  1'b0, 32'h0});
    vecs.push_back('{2, 1'b0, 32'h0000_1040, 32'h0,         0,  1'b0, 32'h0});
    vecs.push_back('{2, 1'b1, 32'h0000_103C, 32'h0F0F_1234, 0,  1'b1, 32'h0});
    vecs.push_back('{2, 1'b0, 32'h0000_103C, 32'h0,         0,  1'b1, 32'h0F0F_1234});
    vecs.push_back('{2, 1'b1, 32'h0000_1000, 32'h0000_0077, 0,  1'b1, 32'h0});
    vecs.push_back('{2, 1'b0, 32'h0000_1002, 32'h0,         0,  1'b1, 32'h0000_0077});

    clr  = 1'b0;
    req  = '0;
    rw   = '0;
    mdrv = '0;
    for (int i = 0; i < 3; i++) begin
      addr[i]  = '0;
      mdata[i] = '0;
    end
    #12;
    for (int unsigned u = 0; u < 3; u++) begin
      chk($sformatf("reset_ready%0d", u), 32'(get_ready(u)), 32'h0);
      chk($sformatf("reset_busy%0d", u), 32'(get_busy(u)), 32'h0);
      chk_rel($sformatf("reset_bus%0d", u), get_bus(u));
    end
    @(negedge clk);
    clr = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Abort: request dropped while waiting, so the write must not land.
    @(negedge clk);
    addr[0] = 32'h0000_0008; rw[0] = 1'b1; mdata[0] = 32'hBADB_AD00; mdrv[0] = 1'b1; req[0] = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 32'(bsy0), 32'h1);
    @(negedge clk);
    req[0] = 1'b0; mdrv[0] = 1'b0;
    rdy_cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rdy0) rdy_cnt++;
    end
    chk("abort_no_ready", rdy_cnt, 0);
    chk("abort_idle", 32'(bsy0), 32'h0);
    rv = '{0, 1'b0, 32'h0000_0008, 32'h0, 0, 1'b1, 32'h1111_2222};
    run_vec(rv, "abort_readback");

    // Asynchronous reset in WAIT: outputs drop without a clock edge and the write is lost.
    @(negedge clk);
    addr[0] = 32'h0000_0004; rw[0] = 1'b1; mdata[0] = 32'h9999_9999; mdrv[0] = 1'b1; req[0] = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_busy_before", 32'(bsy0), 32'h1);
    #2;
    mdrv[0] = 1'b0;
    clr = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(rdy0), 32'h0);
    chk("rst_mid_busy", 32'(bsy0), 32'h0);
    chk_rel("rst_mid_bus", bus0);
    @(negedge clk);
    req[0] = 1'b0;
    clr = 1'b1;
    rv = '{0, 1'b0, 32'h0000_0004, 32'h0, 0, 1'b1, 32'h0ab2_112a};
    run_vec(rv, "rst_readback");

    // Request rising while reset is held: nothing is accepted.
    @(negedge clk);
    clr = 1'b0;
    addr[0] = 32'h0000_0004; rw[0] = 1'b0; req[0] = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_busy", 32'(bsy0), 32'h0);
    chk("rst_req_ready", 32'(rdy0), 32'h0);
    @(negedge clk);
    req[0] = 1'b0;
    clr = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_idle", 32'(bsy0), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
